// File: rtl/rb_pkg.sv
// Shared types and register map for the parametrised register bank.
// Offsets are relative to DEPTH, the first address above the data array.
package rb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } rb_state_e;

    localparam int NUM_REGS      = 4;
    localparam int OFS_LENGTH    = 0;
    localparam int OFS_MAX_BURST = 1;
    localparam int OFS_CTRL      = 2;
    localparam int OFS_STATUS    = 3;

    localparam int CTRL_START = 0;
    localparam int CTRL_RW    = 1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/rb_xfer_fsm.sv
// Transfer sequencer: start pulse, busy/done tracking and sticky error.
// Also holds the STATUS bits, which clear on an RC read of STATUS.
module rb_xfer_fsm
    import rb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      start_wr,
    input  logic      len_nonzero,
    input  logic      db_rb_done,
    input  logic      status_rd,
    input  logic      err_set,
    output rb_state_e state,
    output logic      rb_db_start,
    output logic      busy,
    output logic      done,
    output logic      err
);

    rb_state_e state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start_wr && len_nonzero) begin
                    state_n = START;
                end
            end
            START: state_n = BUSY;
            BUSY: begin
                if (db_rb_done) begin
                    state_n = DONE;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Completion outranks a same-cycle STATUS read so done is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (status_rd) begin
                done <= 1'b0;
                err  <= 1'b0;
            end
            if (state == START) begin
                done <= 1'b0;
            end
            if (state == DONE) begin
                done <= 1'b1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign rb_db_start = (state == START);

endmodule

// File: rtl/register_bank_param.sv
// Register bank between RC and DB: data array, control/status registers,
// registered req/ack handshakes on both ports and state-based ownership.
module register_bank_param
    import rb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rc_rb_req,
    input  logic              rc_rb_rw,
    input  logic [ADDR_W-1:0] rc_rb_addr,
    input  logic [DATA_W-1:0] rc_rb_data,
    output logic              rb_rc_ack,
    output logic [DATA_W-1:0] rb_rc_data,
    output logic              rb_rc_err,
    input  logic              db_rb_req,
    input  logic              db_rb_rw,
    input  logic [ADDR_W-1:0] db_rb_addr,
    input  logic [DATA_W-1:0] db_rb_data,
    input  logic              db_rb_done,
    output logic              rb_db_ack,
    output logic [DATA_W-1:0] rb_db_data,
    output logic              rb_db_start,
    output logic              rb_db_rw,
    output logic [DATA_W-1:0] rb_db_length,
    output logic [DATA_W-1:0] rb_db_max_burst_size,
    output logic              idle
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W:0] ARR_END = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] REG_END = (ADDR_W+1)'(DEPTH + NUM_REGS);

    localparam logic [ADDR_W-1:0] A_LEN  = ADDR_W'(DEPTH + OFS_LENGTH);
    localparam logic [ADDR_W-1:0] A_MB   = ADDR_W'(DEPTH + OFS_MAX_BURST);
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(DEPTH + OFS_CTRL);
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(DEPTH + OFS_STATUS);

    logic [DATA_W-1:0] mem [DEPTH];

    rb_state_e         state;
    logic              st_busy;
    logic              st_done;
    logic              st_err;
    logic [DATA_W-1:0] length_q;
    logic [DATA_W-1:0] max_burst_q;
    logic              ctrl_rw_q;

    logic              rc_acc;
    logic              rc_in_arr;
    logic              rc_oob;
    logic              hit_len;
    logic              hit_mb;
    logic              hit_ctrl;
    logic              hit_stat;
    logic              rc_err_c;
    logic              rc_ok;
    logic              start_wr;
    logic              status_rd;
    logic              len_nonzero;
    logic [IDX_W-1:0]  rc_idx;
    logic [DATA_W-1:0] rc_rdata_c;
    logic [DATA_W-1:0] status_w;
    logic [DATA_W-1:0] ctrl_w;

    logic              db_acc;
    logic              db_ok;
    logic [IDX_W-1:0]  db_idx;
    logic [DATA_W-1:0] db_rdata_c;

    logic              is_idle;

    rb_xfer_fsm u_fsm (
        .clk         (clk),
        .rst         (rst),
        .start_wr    (start_wr),
        .len_nonzero (len_nonzero),
        .db_rb_done  (db_rb_done),
        .status_rd   (status_rd),
        .err_set     (rc_err_c),
        .state       (state),
        .rb_db_start (rb_db_start),
        .busy        (st_busy),
        .done        (st_done),
        .err         (st_err)
    );

    assign is_idle     = (state == IDLE);
    assign len_nonzero = |length_q;
    assign rc_idx      = rc_rb_addr[IDX_W-1:0];
    assign db_idx      = db_rb_addr[IDX_W-1:0];

    always_comb begin
        status_w            = '0;
        status_w[STAT_BUSY] = st_busy;
        status_w[STAT_DONE] = st_done;
        status_w[STAT_ERR]  = st_err;
        ctrl_w              = '0;
        ctrl_w[CTRL_RW]     = ctrl_rw_q;
    end

    always_comb begin
        rc_acc    = rc_rb_req & ~rb_rc_ack;
        rc_in_arr = ({1'b0, rc_rb_addr} < ARR_END);
        rc_oob    = ({1'b0, rc_rb_addr} >= REG_END);
        hit_len   = (rc_rb_addr == A_LEN);
        hit_mb    = (rc_rb_addr == A_MB);
        hit_ctrl  = (rc_rb_addr == A_CTRL);
        hit_stat  = (rc_rb_addr == A_STAT);
        rc_err_c  = rc_acc & (
                      rc_oob
                    | (rc_in_arr & ~is_idle)
                    | (rc_rb_rw & (hit_len | hit_ctrl) & ~is_idle)
                    | (rc_rb_rw & hit_stat)
                    | (rc_rb_rw & hit_ctrl
                       & rc_rb_data[CTRL_START] & ~len_nonzero));
        rc_ok     = rc_acc & ~rc_err_c;
        start_wr  = rc_ok & rc_rb_rw & hit_ctrl & rc_rb_data[CTRL_START];
        status_rd = rc_ok & ~rc_rb_rw & hit_stat;
    end

    always_comb begin
        rc_rdata_c = '0;
        if (rc_ok && !rc_rb_rw) begin
            unique case (1'b1)
                rc_in_arr: rc_rdata_c = mem[rc_idx];
                hit_len:   rc_rdata_c = length_q;
                hit_mb:    rc_rdata_c = max_burst_q;
                hit_ctrl:  rc_rdata_c = ctrl_w;
                hit_stat:  rc_rdata_c = status_w;
                default:   rc_rdata_c = '0;
            endcase
        end
    end

    // DB only touches the array while the transfer is in BUSY.
    always_comb begin
        db_acc     = db_rb_req & ~rb_db_ack;
        db_ok      = db_acc & (state == BUSY)
                   & ({1'b0, db_rb_addr} < ARR_END);
        db_rdata_c = (db_ok && !db_rb_rw) ? mem[db_idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (rc_ok && rc_rb_rw && rc_in_arr) begin
                mem[rc_idx] <= rc_rb_data;
            end else if (db_ok && db_rb_rw) begin
                mem[db_idx] <= db_rb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_rc_ack   <= 1'b0;
            rb_rc_data  <= '0;
            rb_rc_err   <= 1'b0;
            length_q    <= '0;
            max_burst_q <= '0;
            ctrl_rw_q   <= 1'b0;
        end else begin
            rb_rc_ack  <= rc_acc;
            rb_rc_data <= rc_rdata_c;
            rb_rc_err  <= rc_err_c;
            if (rc_ok && rc_rb_rw) begin
                if (hit_len) begin
                    length_q <= rc_rb_data;
                end
                if (hit_mb) begin
                    max_burst_q <= rc_rb_data;
                end
                if (hit_ctrl) begin
                    ctrl_rw_q <= rc_rb_data[CTRL_RW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rb_db_ack  <= 1'b0;
            rb_db_data <= '0;
        end else begin
            rb_db_ack  <= db_acc;
            rb_db_data <= db_rdata_c;
        end
    end

    assign rb_db_rw             = ctrl_rw_q;
    assign rb_db_length         = length_q;
    assign rb_db_max_burst_size = max_burst_q;

    assign idle = is_idle & ~rc_rb_req & ~db_rb_req
                & ~rb_rc_ack & ~rb_db_ack;

endmodule

// File: tb/tb_register_bank_param.sv
// Scoreboard bench for register_bank_param: tasks queue expected
// responses, a negedge monitor pops and compares on every ack.
module tb_register_bank_param;

    localparam int DW  = 8;
    localparam int DEP = 256;
    localparam int AW  = 9;

    localparam logic [AW-1:0] A_LEN  = 9'd256;
    localparam logic [AW-1:0] A_MB   = 9'd257;
    localparam logic [AW-1:0] A_CTRL = 9'd258;
    localparam logic [AW-1:0] A_STAT = 9'd259;
    localparam logic [AW-1:0] A_OOB  = 9'd260;

    logic          clk;
    logic          rst;
    logic          rc_rb_req;
    logic          rc_rb_rw;
    logic [AW-1:0] rc_rb_addr;
    logic [DW-1:0] rc_rb_data;
    logic          rb_rc_ack;
    logic [DW-1:0] rb_rc_data;
    logic          rb_rc_err;
    logic          db_rb_req;
    logic          db_rb_rw;
    logic [AW-1:0] db_rb_addr;
    logic [DW-1:0] db_rb_data;
    logic          db_rb_done;
    logic          rb_db_ack;
    logic [DW-1:0] rb_db_data;
    logic          rb_db_start;
    logic          rb_db_rw;
    logic [DW-1:0] rb_db_length;
    logic [DW-1:0] rb_db_max_burst_size;
    logic          idle;

    register_bank_param #(
        .DATA_W (DW),
        .DEPTH  (DEP),
        .ADDR_W (AW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rc_rb_req            (rc_rb_req),
        .rc_rb_rw             (rc_rb_rw),
        .rc_rb_addr           (rc_rb_addr),
        .rc_rb_data           (rc_rb_data),
        .rb_rc_ack            (rb_rc_ack),
        .rb_rc_data           (rb_rc_data),
        .rb_rc_err            (rb_rc_err),
        .db_rb_req            (db_rb_req),
        .db_rb_rw             (db_rb_rw),
        .db_rb_addr           (db_rb_addr),
        .db_rb_data           (db_rb_data),
        .db_rb_done           (db_rb_done),
        .rb_db_ack            (rb_db_ack),
        .rb_db_data           (rb_db_data),
        .rb_db_start          (rb_db_start),
        .rb_db_rw             (rb_db_rw),
        .rb_db_length         (rb_db_length),
        .rb_db_max_burst_size (rb_db_max_burst_size),
        .idle                 (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;
    int start_cycles = 0;

    logic [DW:0] rc_q[$];
    logic [DW:0] db_q[$];

    always @(negedge clk) begin
        logic [DW:0] e;
        if (rb_db_start) start_cycles++;
        if (rb_rc_ack) begin
            n_vec++;
            if (rc_q.size() == 0) begin
                n_mis++;
                $display("FAIL rc_unexpected_ack got err=%b data=%h required no ack",
                         rb_rc_err, rb_rc_data);
            end else begin
                e = rc_q.pop_front();
                if ({rb_rc_err, rb_rc_data} !== e) begin
                    n_mis++;
                    $display("FAIL rc_resp got err=%b data=%h required err=%b data=%h",
                             rb_rc_err, rb_rc_data, e[DW], e[DW-1:0]);
                end
            end
        end
        if (rb_db_ack) begin
            n_vec++;
            if (db_q.size() == 0) begin
                n_mis++;
                $display("FAIL db_unexpected_ack got data=%h required no ack",
                         rb_db_data);
            end else begin
                e = db_q.pop_front();
                if (rb_db_data !== e[DW-1:0]) begin
                    n_mis++;
                    $display("FAIL db_resp got data=%h required data=%h",
                             rb_db_data, e[DW-1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic rc_xfer(input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] ed,
                           input logic ee);
        int lat;
        bit seen;
        logic [DW:0] tmp;
        rc_q.push_back({ee, ed});
        rc_rb_rw   = rw;
        rc_rb_addr = a;
        rc_rb_data = d;
        rc_rb_req  = 1'b1;
        lat = 0;
        seen = 0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (rb_rc_ack) seen = 1;
        end
        rc_rb_req = 1'b0;
        if (!seen) begin
            n_vec++;
            n_mis++;
            $display("FAIL rc_timeout addr=%h got no ack required ack", a);
            tmp = rc_q.pop_back();
        end else begin
            check("rc_latency", 32'(lat), 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic db_xfer(input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] ed);
        int lat;
        bit seen;
        logic [DW:0] tmp;
        db_q.push_back({1'b0, ed});
        db_rb_rw   = rw;
        db_rb_addr = a;
        db_rb_data = d;
        db_rb_req  = 1'b1;
        lat = 0;
        seen = 0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            lat++;
            if (rb_db_ack) seen = 1;
        end
        db_rb_req = 1'b0;
        if (!seen) begin
            n_vec++;
            n_mis++;
            $display("FAIL db_timeout addr=%h got no ack required ack", a);
            tmp = db_q.pop_back();
        end else begin
            check("db_latency", 32'(lat), 32'd1);
        end
        @(negedge clk);
    endtask

    task automatic pulse_done();
        db_rb_done = 1'b1;
        @(negedge clk);
        db_rb_done = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int acks;
        logic [5:0] pat;
        rst = 1'b1;
        rc_rb_req = 1'b0;
        rc_rb_rw = 1'b0;
        rc_rb_addr = '0;
        rc_rb_data = '0;
        db_rb_req = 1'b0;
        db_rb_rw = 1'b0;
        db_rb_addr = '0;
        db_rb_data = '0;
        db_rb_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_rc_ack", 32'(rb_rc_ack), 32'd0);
        check("rst_rc_data", 32'(rb_rc_data), 32'd0);
        check("rst_db_ack", 32'(rb_db_ack), 32'd0);
        check("rst_start", 32'(rb_db_start), 32'd0);
        check("rst_rw", 32'(rb_db_rw), 32'd0);
        check("rst_length", 32'(rb_db_length), 32'd0);
        check("rst_max_burst", 32'(rb_db_max_burst_size), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);

        // array write/read in IDLE
        rc_xfer(1'b1, 9'd3, 8'hA5, 8'h00, 1'b0);
        rc_xfer(1'b0, 9'd3, 8'h00, 8'hA5, 1'b0);

        // start a transfer and complete it
        rc_xfer(1'b1, A_LEN, 8'd4, 8'h00, 1'b0);
        rc_xfer(1'b1, A_MB, 8'd2, 8'h00, 1'b0);
        rc_xfer(1'b0, A_LEN, 8'h00, 8'd4, 1'b0);
        s0 = start_cycles;
        rc_xfer(1'b1, A_CTRL, 8'h03, 8'h00, 1'b0);
        check("start_pulse_cycles", 32'(start_cycles - s0), 32'd1);
        check("busy_rw", 32'(rb_db_rw), 32'd1);
        check("busy_length", 32'(rb_db_length), 32'd4);
        check("busy_max_burst", 32'(rb_db_max_burst_size), 32'd2);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h01, 1'b0);
        rc_xfer(1'b0, A_CTRL, 8'h00, 8'h02, 1'b0);
        pulse_done();
        check("idle_after_done", 32'(idle), 32'd1);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h02, 1'b0);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h00, 1'b0);

        // DB owns the array during BUSY
        s0 = start_cycles;
        rc_xfer(1'b1, A_CTRL, 8'h03, 8'h00, 1'b0);
        check("start_pulse_2", 32'(start_cycles - s0), 32'd1);
        for (int i = 0; i < 4; i++) begin
            db_xfer(1'b1, AW'(i), DW'(8'h11 + i), 8'h00);
        end
        rc_xfer(1'b0, 9'd0, 8'h00, 8'h00, 1'b1);
        rc_xfer(1'b1, A_LEN, 8'd9, 8'h00, 1'b1);
        rc_xfer(1'b1, A_MB, 8'd5, 8'h00, 1'b0);
        rc_xfer(1'b0, A_MB, 8'h00, 8'd5, 1'b0);
        check("len_kept", 32'(rb_db_length), 32'd4);
        db_xfer(1'b0, 9'd1, 8'h00, 8'h12);
        db_xfer(1'b1, 9'd300, 8'h77, 8'h00);
        db_xfer(1'b0, 9'd300, 8'h00, 8'h00);
        check("busy_not_idle", 32'(idle), 32'd0);
        pulse_done();
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h06, 1'b0);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            rc_xfer(1'b0, AW'(i), 8'h00, DW'(8'h11 + i), 1'b0);
        end
        db_xfer(1'b1, 9'd0, 8'hFF, 8'h00);
        rc_xfer(1'b0, 9'd0, 8'h00, 8'h11, 1'b0);

        // error cases
        rc_xfer(1'b1, A_LEN, 8'd0, 8'h00, 1'b0);
        s0 = start_cycles;
        rc_xfer(1'b1, A_CTRL, 8'h01, 8'h00, 1'b1);
        rc_xfer(1'b0, A_OOB, 8'h00, 8'h00, 1'b1);
        rc_xfer(1'b1, A_STAT, 8'h07, 8'h00, 1'b1);
        rc_xfer(1'b0, 9'h1FF, 8'h00, 8'h00, 1'b1);
        check("no_start_on_err", 32'(start_cycles - s0), 32'd0);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h04, 1'b0);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h00, 1'b0);
        pulse_done();
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h00, 1'b0);
        rc_xfer(1'b0, A_CTRL, 8'h00, 8'h02, 1'b0);

        // reset in the middle of a transfer
        rc_xfer(1'b1, A_LEN, 8'd3, 8'h00, 1'b0);
        rc_xfer(1'b1, A_CTRL, 8'h01, 8'h00, 1'b0);
        check("rw_cleared", 32'(rb_db_rw), 32'd0);
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h01, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_idle", 32'(idle), 32'd1);
        check("mid_rst_length", 32'(rb_db_length), 32'd0);
        check("mid_rst_max_burst", 32'(rb_db_max_burst_size), 32'd0);
        check("mid_rst_start", 32'(rb_db_start), 32'd0);
        s0 = start_cycles;
        pulse_done();
        rc_xfer(1'b0, A_STAT, 8'h00, 8'h00, 1'b0);
        rc_xfer(1'b0, A_LEN, 8'h00, 8'h00, 1'b0);
        check("no_start_after_rst", 32'(start_cycles - s0), 32'd0);

        // held request gives one ack every other cycle
        rc_xfer(1'b1, A_MB, 8'h3C, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) rc_q.push_back({1'b0, 8'h3C});
        rc_rb_rw   = 1'b0;
        rc_rb_addr = A_MB;
        rc_rb_req  = 1'b1;
        acks = 0;
        pat  = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat = {pat[4:0], rb_rc_ack};
            if (rb_rc_ack) acks++;
        end
        rc_rb_req = 1'b0;
        @(negedge clk);
        check("held_ack_count", 32'(acks), 32'd3);
        check("held_ack_pattern", 32'(pat), 32'h2A);

        repeat (3) @(negedge clk);
        check("rc_queue_drained", 32'(rc_q.size()), 32'd0);
        check("db_queue_drained", 32'(db_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/register_bank_param.md
Name: register_bank_param

Overview:
- Parametrised register bank between the register controller (RC) and the data burst controller (DB).
- Holds a DEPTH-entry data array plus four control/status registers mapped directly above the array.
- Replaces the fixed 8-bit/256-entry bank with registered req/ack handshakes on both ports, a transfer FSM, and error reporting.
- The FSM issues a single-cycle start pulse, tracks busy/done and arbitrates data-array ownership.

Parameters:
- DATA_W, 8: data width of array entries and control registers.
- DEPTH, 256: number of data-array entries.
- ADDR_W, 9: address width; must satisfy 2**ADDR_W >= DEPTH+4.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- rc_rb_req  in  1  RC access request, level, held until ack.
- rc_rb_rw  in  1  1 = write, 0 = read.
- rc_rb_addr  in  ADDR_W  RC address.
- rc_rb_data  in  DATA_W  RC write data.
- rb_rc_ack  out  1  one-cycle acknowledge to RC.
- rb_rc_data  out  DATA_W  RC read data, valid with ack.
- rb_rc_err  out  1  error qualifier, valid with ack.
- db_rb_req  in  1  DB access request, level.
- db_rb_rw  in  1  1 = DB writes array (burst read), 0 = DB reads array.
- db_rb_addr  in  ADDR_W  DB array index.
- db_rb_data  in  DATA_W  DB write data.
- db_rb_done  in  1  DB transfer complete, one-cycle pulse.
- rb_db_ack  out  1  one-cycle acknowledge to DB.
- rb_db_data  out  DATA_W  DB read data, valid with ack.
- rb_db_start  out  1  one-cycle start pulse.
- rb_db_rw  out  1  transfer direction, CTRL[1].
- rb_db_length  out  DATA_W  LENGTH register.
- rb_db_max_burst_size  out  DATA_W  MAX_BURST register.
- idle  out  1  block quiescent.

Behaviour:
- Address map: 0..DEPTH-1 data array; DEPTH LENGTH (RW); DEPTH+1 MAX_BURST (RW); DEPTH+2 CTRL (RW, bit0 start self-clearing, reads 0; bit1 rw); DEPTH+3 STATUS (RO: bit0 busy, bit1 done, bit2 err).
- Reset values: all outputs 0; LENGTH, MAX_BURST, CTRL, STATUS = 0; FSM = IDLE. Data array is not reset.
- Handshake (each port): a request is accepted when req=1 and ack=0. ack is registered and asserts exactly 1 cycle after acceptance. Read data and err are valid in the ack cycle and are 0 when ack=0. A req still high in the ack cycle is not accepted, so back-to-back accesses give at most one ack every 2 cycles.
- FSM states: IDLE, START, BUSY, DONE.
  - IDLE -> START on an accepted RC write to CTRL with bit0=1 and LENGTH != 0.
  - START (1 cycle): rb_db_start=1; clears STATUS.done; -> BUSY.
  - BUSY: -> DONE on db_rb_done.
  - DONE (1 cycle): sets STATUS.done; -> IDLE.
- STATUS.busy = (state != IDLE). rb_db_rw = CTRL[1], captured on the start write.
- Array ownership: RC owns the array in IDLE; DB owns it in START/BUSY/DONE.
- RC accesses that error (ack with err=1, no state change, read data 0):
  - array access while not IDLE;
  - write to CTRL or LENGTH while not IDLE;
  - start with LENGTH == 0;
  - write to STATUS;
  - address >= DEPTH+4.
- MAX_BURST is writable in any state.
- DB request outside BUSY: acked, write dropped, rb_db_data = 0. DB address >= DEPTH: same treatment.
- Any RC error sets sticky STATUS.err. An RC read of STATUS returns the current value, then clears done and err in the same cycle the ack asserts.
- db_rb_done outside BUSY is ignored.
- Simultaneous RC and DB requests are independent; no cross-port stall, because ownership is state-based.
- idle = (state == IDLE) & ~rc_rb_req & ~db_rb_req & ~rb_rc_ack & ~rb_db_ack.
- rst asserted mid-transfer: the next cycle is IDLE with all registers and outputs 0. Any pending ack is dropped.

Decomposition:
- Shared package rb_pkg holds:
  - state enum {IDLE, START, BUSY, DONE};
  - register offsets OFS_LENGTH=0, OFS_MAX_BURST=1, OFS_CTRL=2, OFS_STATUS=3;
  - CTRL/STATUS bit indices.
- One sub-module, rb_xfer_fsm: FSM plus STATUS bits. Inputs are start_wr, len_nonzero, db_rb_done and status_rd. Outputs are state, rb_db_start and the status bits.
- Array, decode and handshake logic stay in the top level.

Test Plan:
1. RC writes 0xA5 to addr 3, then reads addr 3 -> ack 1 cycle after each accepted req; read returns 0xA5 with err=0.
2. Write LENGTH=4, MAX_BURST=2, then CTRL=0x03 -> rb_db_start high exactly 1 cycle, rb_db_rw=1, STATUS reads 0x01. After a DB done pulse, STATUS reads 0x02, then 0x00 on re-read.
3. During BUSY, DB writes 0x11..0x14 to addr 0..3 and RC reads addr 0 -> DB acks; RC gets err=1, data 0. After DONE, RC reads addr 0..3 = 0x11..0x14.
4. Start with LENGTH=0; access addr DEPTH+4; write STATUS -> each returns err=1, no start pulse; STATUS.err=1 until read.
5. rst asserted for 1 cycle mid-BUSY -> next cycle STATUS=0, idle=1. db_rb_done then has no effect.
6. RC holds req high continuously for 6 cycles -> exactly 3 acks, on alternate cycles.
